enemy_shot_selector: RTL
========================

// Module: enemy_shot_selector
// PURPOSE
//   Chooses which alien fires next and when. Every FIRE_PERIOD cycles of active play it picks a pseudo-random
//   start column and scans the columns, wrapping around, for the first one that still has a live alien. It fires
//   from the bottom-most live alien in that column. It drives the ID_enemy_tiro_X/Y indices and a one-cycle fire
//   pulse. The top level turns these into posX_tiro_inimigo/posY_tiro_inimigo, which feed municao2.
// PARAMETERS
//   LINHAS       4           rows of aliens; row 0 is the top row
//   COLUNAS      10          aliens per row; flat index = row*COLUNAS + col
//   FIRE_PERIOD  12_500_000  clk cycles between shot attempts (0.25 s at 50 MHz); must be >= 2
//   LFSR_SEED    16'hACE1    LFSR reset value; must be nonzero
// PORTS
//   clk              in   1                clock, all logic on posedge
//   reset            in   1                synchronous, active-low reset
//   enable           in   1                high only while the game state is "jogo em andamento"
//   vivo_inimigo     in   LINHAS*COLUNAS   alive mask, bit [row*COLUNAS+col]
//   shot_busy        in   1                an enemy bullet is still in flight; no new shot is allowed
//   fire             out  1                one-cycle pulse; the IDs are valid in the same cycle
//   ID_enemy_tiro_X  out  10               flat index of the shooter
//   ID_enemy_tiro_Y  out  10               row of the shooter
//   no_target        out  1                one-cycle pulse when a full scan finds no live alien
// BEHAVIOUR
//   - Reset (reset==0 at posedge):
//     - outputs: fire=0, no_target=0, IDs=0
//     - internal: state=WAIT, timer=0, lfsr=LFSR_SEED
//     - a reset during SCAN or FIRE aborts the shot; no pulse is issued.
//   - LFSR: 16-bit Galois, taps x^16+x^14+x^13+x^11 (mask 16'hB400).
//     - Steps every cycle when not in reset, independent of enable.
//     - start column = lfsr % COLUNAS, sampled in PICK.
//   - WAIT:
//     - enable==0: timer is held at 0.
//     - otherwise timer increments and saturates at FIRE_PERIOD-1.
//     - timer==FIRE_PERIOD-1 and shot_busy==0 -> PICK. While shot_busy is high the timer stays saturated.
//   - PICK (1 cycle): cur_col = lfsr % COLUNAS, scan_cnt = 0 -> SCAN.
//   - SCAN (1 cycle per column):
//     - Find the highest row r with vivo_inimigo[r*COLUNAS+cur_col]==1.
//     - Hit: register ID_enemy_tiro_X = r*COLUNAS+cur_col and ID_enemy_tiro_Y = r -> FIRE.
//     - Miss and scan_cnt==COLUNAS-1: no_target=1 for one cycle, timer=0 -> WAIT.
//     - Miss otherwise: cur_col = (cur_col==COLUNAS-1) ? 0 : cur_col+1, scan_cnt++.
//   - FIRE: fire=1 for exactly this cycle, timer=0 -> WAIT.
//     - The IDs hold their value until the next hit, so they stay stable for the top-level muxing.
//   - Latency: from the timer reaching FIRE_PERIOD-1 (shot_busy low) to fire is 3+k cycles,
//     where k = number of empty columns skipped.
//   - enable falling in PICK, SCAN or FIRE -> WAIT next cycle, timer=0, no fire, no no_target.
//   - vivo_inimigo is sampled live each SCAN cycle; a kill in the same cycle uses the current mask.
//   - shot_busy is checked only in WAIT; it rising during SCAN does not cancel the shot.
//   - Width rules: the IDs are zero-extended to 10 bits; all timer and scan arithmetic is unsigned with no wrap.
// TESTING
//   1. Reset low for 3 cycles -> fire=0, no_target=0, IDs=0. Then enable=1, all alive, shot_busy=0.
//      First fire at cycle FIRE_PERIOD+2 after enable. IDs = (3*10+c, 3), where c = model_lfsr % 10.
//   2. Column c has only rows 0..1 alive -> ID_Y=1, ID_X=10+c. Column c fully dead and c+1 alive -> one extra
//      cycle, ID_X=30+(c+1)%10.
//   3. Wrap: start column 9 empty, column 0 alive -> ID_X=30, ID_Y=3.
//   4. All aliens dead -> no_target pulses every FIRE_PERIOD+11 cycles, fire never asserts.
//   5. shot_busy high across the timer expiry for 100 cycles -> no fire; fire occurs 3 cycles after shot_busy falls.
//   6. reset asserted mid-SCAN -> no fire or no_target that round, registers back to reset values.
//      Also enable dropped in PICK -> WAIT with timer 0.

Source files
------------

// File: rtl/enemy_shot_selector.sv
// Picks the next alien shooter: a timer paces shot attempts, an LFSR picks a start column, and a
// column-per-cycle scan finds the bottom-most live alien, wrapping around the columns.
module enemy_shot_selector #(
  parameter int          LINHAS      = 4,
  parameter int          COLUNAS     = 10,
  parameter int          FIRE_PERIOD = 12_500_000,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic [LINHAS*COLUNAS-1:0] vivo_inimigo,
  input  logic                      shot_busy,
  output logic                      fire,
  output logic [9:0]                ID_enemy_tiro_X,
  output logic [9:0]                ID_enemy_tiro_Y,
  output logic                      no_target
);

  localparam int TW = $clog2(FIRE_PERIOD);
  localparam int CW = (COLUNAS > 1) ? $clog2(COLUNAS) : 1;
  localparam int RW = (LINHAS > 1) ? $clog2(LINHAS) : 1;
  localparam logic [TW-1:0] TMAX     = TW'(FIRE_PERIOD - 1);
  localparam logic [CW-1:0] LAST_COL = CW'(COLUNAS - 1);

  typedef enum logic [1:0] {S_WAIT, S_PICK, S_SCAN, S_FIRE} state_t;

  state_t        state, state_next;
  logic [TW-1:0] timer, timer_next;
  logic [15:0]   lfsr, lfsr_next;
  logic [CW-1:0] cur_col, cur_col_next;
  logic [CW-1:0] scan_cnt, scan_cnt_next;
  logic          fire_next, no_target_next;
  logic [9:0]    id_x_next, id_y_next;
  logic [CW-1:0] start_col;
  logic          hit;
  logic [RW-1:0] hit_row;

  assign lfsr_next = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
  assign start_col = CW'(lfsr % 16'(COLUNAS));

  // Later (lower) rows overwrite earlier ones, so the bottom-most live alien wins.
  always_comb begin
    hit     = 1'b0;
    hit_row = '0;
    for (int r = 0; r < LINHAS; r++) begin
      if (vivo_inimigo[r*COLUNAS + int'(cur_col)]) begin
        hit     = 1'b1;
        hit_row = r[RW-1:0];
      end
    end
  end

  always_comb begin
    state_next     = state;
    timer_next     = timer;
    cur_col_next   = cur_col;
    scan_cnt_next  = scan_cnt;
    fire_next      = 1'b0;
    no_target_next = 1'b0;
    id_x_next      = ID_enemy_tiro_X;
    id_y_next      = ID_enemy_tiro_Y;
    case (state)
      S_WAIT: begin
        if (!enable) begin
          timer_next = '0;
        end else if (timer == TMAX && !shot_busy) begin
          state_next = S_PICK;
        end else if (timer != TMAX) begin
          timer_next = timer + 1'b1;
        end
      end
      S_PICK: begin
        timer_next = '0;
        if (!enable) begin
          state_next = S_WAIT;
        end else begin
          cur_col_next  = start_col;
          scan_cnt_next = '0;
          state_next    = S_SCAN;
        end
      end
      S_SCAN: begin
        timer_next = '0;
        if (!enable) begin
          state_next = S_WAIT;
        end else if (hit) begin
          id_x_next  = 10'(int'(hit_row) * COLUNAS + int'(cur_col));
          id_y_next  = 10'(hit_row);
          fire_next  = 1'b1;
          state_next = S_FIRE;
        end else if (scan_cnt == LAST_COL) begin
          no_target_next = 1'b1;
          state_next     = S_WAIT;
        end else begin
          cur_col_next  = (cur_col == LAST_COL) ? '0 : cur_col + 1'b1;
          scan_cnt_next = scan_cnt + 1'b1;
        end
      end
      S_FIRE: begin
        timer_next = '0;
        state_next = S_WAIT;
      end
      default: begin
        timer_next = '0;
        state_next = S_WAIT;
      end
    endcase
  end

  // fire and no_target are registered so each is high for exactly the cycle after its decision.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state           <= S_WAIT;
      timer           <= '0;
      lfsr            <= LFSR_SEED;
      cur_col         <= '0;
      scan_cnt        <= '0;
      fire            <= 1'b0;
      no_target       <= 1'b0;
      ID_enemy_tiro_X <= '0;
      ID_enemy_tiro_Y <= '0;
    end else begin
      state           <= state_next;
      timer           <= timer_next;
      lfsr            <= lfsr_next;
      cur_col         <= cur_col_next;
      scan_cnt        <= scan_cnt_next;
      fire            <= fire_next;
      no_target       <= no_target_next;
      ID_enemy_tiro_X <= id_x_next;
      ID_enemy_tiro_Y <= id_y_next;
    end
  end

endmodule
